// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to the device over open-drain ps2_clk/ps2_data:
// inhibits the clock, issues request-to-send, shifts bits out on
// device-generated falling edges, checks the device ack, and then waits
// for the bus to go idle. busy lets the top level gate the keyboard receiver.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t state, state_next;

    logic             clk_meta, clk_sync, clk_prev;
    logic             data_meta, data_sync;
    logic             fe;

    logic [9:0]       shift, shift_next;
    logic [3:0]       bitcnt, bitcnt_next;
    logic [INH_W-1:0] inh_cnt, inh_cnt_next;
    logic [TO_W-1:0]  to_cnt, to_cnt_next;
    logic             data_q, data_q_next;
    logic             ackbit, ackbit_next;
    logic             done_next, ack_err_next, timeout_next;

    // Two-flop synchronisers for both pad inputs plus a delayed copy of the
    // synced clock for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: synchronisers reset to the idle bus level (1) so leaving
            // reset cannot manufacture a falling edge on ps2_clk.
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the value
            // from before this edge; blocking here would collapse the chain.
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    assign fe = clk_prev & ~clk_sync;

    // State register and datapath registers, all loaded from the next-state logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shift   <= '0;
            bitcnt  <= '0;
            inh_cnt <= '0;
            to_cnt  <= '0;
            data_q  <= 1'b0;
            ackbit  <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_next;
            shift   <= shift_next;
            bitcnt  <= bitcnt_next;
            inh_cnt <= inh_cnt_next;
            to_cnt  <= to_cnt_next;
            data_q  <= data_q_next;
            ackbit  <= ackbit_next;
            done    <= done_next;
            ack_err <= ack_err_next;
            timeout <= timeout_next;
        end
    end

    // Next-state, counter and pulse logic; abort on timeout overrides any fe.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_next   = state;
        shift_next   = shift;
        bitcnt_next  = bitcnt;
        inh_cnt_next = inh_cnt;
        to_cnt_next  = to_cnt;
        data_q_next  = data_q;
        ackbit_next  = ackbit;
        done_next    = 1'b0;
        ack_err_next = 1'b0;
        timeout_next = 1'b0;

        case (state)
            IDLE: begin
                if (tx_valid) begin
                    // Frame after the start bit: data LSB first, odd parity, stop.
                    shift_next   = {1'b1, ~^tx_data, tx_data};
                    inh_cnt_next = '0;
                    to_cnt_next  = '0;
                    bitcnt_next  = '0;
                    state_next   = INHIBIT;
                end
            end

            INHIBIT: begin
                if (inh_cnt == INH_LAST) begin
                    state_next = REQ;
                end else begin
                    inh_cnt_next = inh_cnt + 1'b1;
                end
            end

            REQ: begin
                // Start bit keeps being driven low until the device's first fe.
                data_q_next = 1'b1;
                bitcnt_next = '0;
                to_cnt_next = '0;
                state_next  = SEND;
            end

            SEND, ACK, WAIT_IDLE: begin
                if (to_cnt == TO_LAST) begin
                    timeout_next = 1'b1;
                    data_q_next  = 1'b0;
                    state_next   = IDLE;
                end else begin
                    to_cnt_next = to_cnt + 1'b1;
                    if (state == SEND) begin
                        if (fe) begin
                            data_q_next = ~shift[0];
                            shift_next  = {1'b0, shift[9:1]};
                            bitcnt_next = bitcnt + 4'd1;
                            if (bitcnt == 4'd9) begin
                                state_next = ACK;
                            end
                        end
                    end else if (state == ACK) begin
                        if (fe) begin
                            ackbit_next = data_sync;
                            state_next  = WAIT_IDLE;
                        end
                    end else begin
                        if (clk_sync && data_sync) begin
                            done_next    = 1'b1;
                            ack_err_next = ackbit;
                            state_next   = IDLE;
                        end
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign tx_ready    = (state == IDLE);
    assign busy        = ~tx_ready;
    assign ps2_clk_oe  = (state == INHIBIT) || (state == REQ);
    assign ps2_data_oe = (state == REQ) || ((state == SEND) && data_q);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: a behavioural PS/2 device on open-drain lines,
// a stimulus process that queues expected results, and a monitor that
// compares whenever the DUT signals done or timeout.
module tb_ps2_host_tx;

    localparam int INH  = 8;
    localparam int TO   = 2000;
    localparam int HALF = 20;

    typedef struct {
        logic [7:0] data;
        logic       parity;
        logic       ack_err;
        logic       is_timeout;
    } exp_t;

    exp_t        exp_q[$];
    logic [10:0] frame_q[$];

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk, ps2_data;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, busy, done, ack_err, timeout;

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    int   dev_mode     = 0;   // 0 ack low, 1 leave data high (nack), 2 never clock
    int   dev_idx      = 0;
    logic dev_busy     = 1'b0;

    int errors    = 0;
    int checks    = 0;
    int evt_count = 0;

    assign ps2_clk  = ~(ps2_clk_oe  | dev_clk_low);
    assign ps2_data = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Device model: samples the data line just before each falling clock,
    // so the captured frame is start, 8 data bits, parity, stop.
    initial begin : device
        logic [10:0] bits;
        bits = '0;
        forever begin
            @(negedge clk);
            if (!rst && ps2_clk && !ps2_data) begin
                dev_busy = 1'b1;
                dev_idx  = 0;
                if (dev_mode == 2) begin
                    while (!ps2_data) @(negedge clk);
                end else begin
                    for (int i = 0; i < 11; i++) begin
                        repeat (HALF) @(negedge clk);
                        bits[i] = ps2_data;
                        dev_idx = i;
                        if (i == 10) begin
                            if (dev_mode == 0) dev_data_low = 1'b1;
                            repeat (4) @(negedge clk);
                        end
                        dev_clk_low = 1'b1;
                        repeat (HALF) @(negedge clk);
                        dev_clk_low = 1'b0;
                    end
                    frame_q.push_back(bits);
                    repeat (HALF) @(negedge clk);
                    dev_data_low = 1'b0;
                end
                dev_busy = 1'b0;
            end
        end
    end

    // Monitor: tracks inhibit/request lengths and SEND age, and checks every
    // done/timeout against the head of the expected queue.
    int          inh_len  = 0;
    int          req_len  = 0;
    int          send_cnt = -1;
    exp_t        mon_e;
    logic [10:0] mon_f;

    always @(negedge clk) begin
        if (rst) begin
            inh_len  = 0;
            req_len  = 0;
            send_cnt = -1;
        end else begin
            if (send_cnt >= 0) send_cnt++;
            if (ps2_clk_oe && !ps2_data_oe) begin
                inh_len++;
            end else if (ps2_clk_oe && ps2_data_oe) begin
                if (req_len == 0) check("inhibit_len", inh_len, INH);
                req_len++;
            end else if (req_len != 0) begin
                check("req_len", req_len, 1);
                send_cnt = 0;
                inh_len  = 0;
                req_len  = 0;
            end

            if (done || timeout) begin
                evt_count++;
                check("tx_ready_at_end", tx_ready, 1);
                check("busy_at_end", busy, 0);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_done_or_timeout");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done", done, !mon_e.is_timeout);
                    check("timeout", timeout, mon_e.is_timeout);
                    check("ack_err", ack_err, mon_e.ack_err);
                    if (mon_e.is_timeout) begin
                        check("timeout_latency", send_cnt, TO);
                        check("clk_oe_at_timeout", ps2_clk_oe, 0);
                        check("data_oe_at_timeout", ps2_data_oe, 0);
                    end else if (frame_q.size() == 0) begin
                        fail_now("no_frame_captured");
                    end else begin
                        mon_f = frame_q.pop_front();
                        check("frame", mon_f, {1'b1, mon_e.parity, mon_e.data, 1'b0});
                    end
                end
                send_cnt = -1;
            end
        end
    end

    task automatic push_exp(input logic [7:0] d, input logic p, input int mode);
        exp_t e;
        e.data       = d;
        e.parity     = p;
        e.ack_err    = (mode == 1);
        e.is_timeout = (mode == 2);
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [7:0] d, input logic p, input int mode);
        dev_mode = mode;
        push_exp(d, p, mode);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = ~d;
    endtask

    task automatic wait_event(input string name);
        int start;
        int n;
        start = evt_count;
        n = 0;
        while (evt_count == start && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (evt_count == start) fail_now({name, "_no_completion"});
    endtask

    task automatic wait_dev_idle();
        int n;
        n = 0;
        while (dev_busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (dev_busy) fail_now("device_never_idle");
        repeat (5) @(negedge clk);
    endtask

    // Watchdog so the run always ends even if every bounded wait misbehaves.
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        int start;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx_ready", tx_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_clk_oe", ps2_clk_oe, 0);
        check("reset_data_oe", ps2_data_oe, 0);
        check("reset_pulses", {done, ack_err, timeout}, 3'b000);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 0xED: six ones -> parity 1; device acks low.
        issue(8'hED, 1'b1, 0);
        wait_event("ed_ack");
        wait_dev_idle();

        // 0xF4: five ones -> parity 0.
        issue(8'hF4, 1'b0, 0);
        wait_event("f4_ack");
        wait_dev_idle();

        // 0x00: zero ones -> parity 1.
        issue(8'h00, 1'b1, 0);
        wait_event("00_ack");
        wait_dev_idle();

        // 0xED with device leaving data high on the 11th clock.
        issue(8'hED, 1'b1, 1);
        wait_event("ed_nack");
        wait_dev_idle();

        // Device never clocks: abort after TO cycles in SEND.
        issue(8'hA5, 1'b1, 2);
        wait_event("timeout");
        wait_dev_idle();

        // Reset while the device is clocking data bit 4 of 0xED.
        dev_mode = 0;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hED;
        @(negedge clk);
        tx_valid = 1'b0;
        n = 0;
        while (dev_idx != 5 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (dev_idx != 5) fail_now("reset_test_never_reached_bit4");
        start = evt_count;
        #2;
        rst = 1'b1;
        #1;
        check("clk_oe_async_reset", ps2_clk_oe, 0);
        check("data_oe_async_reset", ps2_data_oe, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_dev_idle();
        frame_q.delete();
        check("no_event_after_reset", evt_count, start);
        check("ready_after_reset", tx_ready, 1);

        issue(8'hF4, 1'b0, 0);
        wait_event("f4_after_reset");
        wait_dev_idle();

        // tx_valid held high, tx_data changing mid-transfer.
        // 0x12: two ones -> parity 1; 0x34: three ones -> parity 0.
        dev_mode = 0;
        push_exp(8'h12, 1'b1, 0);
        push_exp(8'h34, 1'b0, 0);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h12;
        @(negedge clk);
        check("busy_after_accept", busy, 1);
        tx_data = 8'h56;
        repeat (100) @(negedge clk);
        tx_data = 8'h34;
        n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            fail_now("held_valid_first_no_done");
        end else begin
            check("ready_with_done", tx_ready, 1);
            @(negedge clk);
            check("accept_after_done_busy", busy, 1);
            check("accept_after_done_clk_oe", ps2_clk_oe, 1);
        end
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        wait_event("held_valid_second");
        wait_dev_idle();

        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
